// File: rtl/fpadd_result_queue.sv
`timescale 1ns/1ps
// Result queue behind the FP adder: a DEPTH-entry circular FIFO of {result, flags, denorm}
// plus sticky exception flags and a saturating count of denormal results.
module fpadd_result_queue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [63:0]            in_result,
  input  logic [4:0]             in_flags,
  input  logic                   in_denorm,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_result,
  output logic [4:0]             out_flags,
  output logic                   out_denorm,
  input  logic                   clr_flags,
  output logic [4:0]             sticky_flags,
  output logic [7:0]             denorm_cnt,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [63:0]   mem_result [DEPTH];
  logic [4:0]    mem_flags  [DEPTH];
  logic          mem_denorm [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [7:0]    denorm_base;

  // in_ready looks only at occupancy, so a full queue refuses a push even while popping.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Gating on out_valid keeps unreset storage from ever showing at the outputs.
  always_comb begin
    out_result = '0;
    out_flags  = '0;
    out_denorm = 1'b0;
    if (out_valid) begin
      out_result = mem_result[rd_ptr];
      out_flags  = mem_flags[rd_ptr];
      out_denorm = mem_denorm[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_flags[wr_ptr]  <= in_flags;
      mem_denorm[wr_ptr] <= in_denorm;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear is applied first, then the accepted result accumulates on top of it.
  assign denorm_base = clr_flags ? 8'd0 : denorm_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_flags <= '0;
      denorm_cnt   <= '0;
    end else begin
      if (clr_flags)
        sticky_flags <= push ? in_flags : 5'd0;
      else if (push)
        sticky_flags <= sticky_flags | in_flags;

      if (push && in_denorm && (denorm_base != 8'hFF))
        denorm_cnt <= denorm_base + 8'd1;
      else
        denorm_cnt <= denorm_base;
    end
  end

endmodule

// File: tb/tb_fpadd_result_queue.sv
`timescale 1ns/1ps
// Bench for fpadd_result_queue: a directed vector table, corner sequences and random
// traffic, all compared against a queue-based reference model.
module tb_fpadd_result_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_result;
  logic [4:0]  in_flags;
  logic        in_denorm;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_flags;
  logic        out_denorm;
  logic        clr_flags;
  logic [4:0]  sticky_flags;
  logic [7:0]  denorm_cnt;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        in_valid;
    logic [63:0] in_result;
    logic [4:0]  in_flags;
    logic        out_ready;
    logic        clr_flags;
    int          exp_count;
    logic        exp_ready;
    logic        exp_valid;
    logic [63:0] exp_result;
    logic [4:0]  exp_oflags;
    logic [4:0]  exp_sticky;
  } vec_t;

  vec_t vecs[$];

  // Reference model: the queue contents plus the sticky/counter state.
  logic [63:0] m_res[$];
  logic [4:0]  m_flg[$];
  logic        m_den[$];
  logic [4:0]  m_sticky;
  int          m_dcnt;

  fpadd_result_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_result(in_result),
    .in_flags(in_flags), .in_denorm(in_denorm), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .out_denorm(out_denorm), .clr_flags(clr_flags),
    .sticky_flags(sticky_flags), .denorm_cnt(denorm_cnt), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] ent(input int n);
    return 64'hDA7A_0000_0000_0000 | 64'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_res.delete();
    m_flg.delete();
    m_den.delete();
    m_sticky = '0;
    m_dcnt   = 0;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge.
  task automatic apply_stimulus(input logic v, input logic [63:0] r, input logic [4:0] f,
                                input logic d, input logic ordy, input logic clr);
    bit do_push, do_pop;
    logic [63:0] drop_res;
    logic [4:0]  drop_flg;
    logic        drop_den;
    in_valid  = v;
    in_result = r;
    in_flags  = f;
    in_denorm = d;
    out_ready = ordy;
    clr_flags = clr;
    do_push = v && (m_res.size() < DEPTH);
    do_pop  = ordy && (m_res.size() > 0);
    @(posedge clk);
    if (do_pop) begin
      drop_res = m_res.pop_front();
      drop_flg = m_flg.pop_front();
      drop_den = m_den.pop_front();
    end
    if (do_push) begin
      m_res.push_back(r);
      m_flg.push_back(f);
      m_den.push_back(d);
    end
    if (clr) m_sticky = '0;
    if (clr) m_dcnt = 0;
    if (do_push) m_sticky = m_sticky | f;
    if (do_push && d && m_dcnt < 255) m_dcnt = m_dcnt + 1;
    @(negedge clk);
  endtask

  task automatic check_output(input string tag);
    logic [63:0] e_res;
    logic [4:0]  e_flg;
    logic        e_den;
    e_res = '0;
    e_flg = '0;
    e_den = 1'b0;
    if (m_res.size() > 0) begin
      e_res = m_res[0];
      e_flg = m_flg[0];
      e_den = m_den[0];
    end
    check({tag, ".count"},      64'(count),        64'(m_res.size()));
    check({tag, ".in_ready"},   64'(in_ready),     64'(m_res.size() < DEPTH));
    check({tag, ".out_valid"},  64'(out_valid),    64'(m_res.size() != 0));
    check({tag, ".out_result"}, out_result,        e_res);
    check({tag, ".out_flags"},  64'(out_flags),    64'(e_flg));
    check({tag, ".out_denorm"}, 64'(out_denorm),   64'(e_den));
    check({tag, ".sticky"},     64'(sticky_flags), 64'(m_sticky));
    check({tag, ".denorm_cnt"}, 64'(denorm_cnt),   64'(m_dcnt));
  endtask

  task automatic add_vec(input logic v, input logic [63:0] r, input logic [4:0] f,
                         input logic ordy, input logic clr, input int ecnt, input logic erdy,
                         input logic evld, input logic [63:0] eres, input logic [4:0] eflg,
                         input logic [4:0] estk);
    vec_t t;
    t.in_valid = v;   t.in_result = r;   t.in_flags = f;
    t.out_ready = ordy; t.clr_flags = clr;
    t.exp_count = ecnt; t.exp_ready = erdy; t.exp_valid = evld;
    t.exp_result = eres; t.exp_oflags = eflg; t.exp_sticky = estk;
    vecs.push_back(t);
  endtask

  initial begin
    string name;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    in_flags  = '0;
    in_denorm = 1'b0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    model_reset();

    // Single entry, then pop and clear.
    add_vec(1, 64'h404FD1EB851EB852, 5'b00001, 0, 0, 1, 1, 1, 64'h404FD1EB851EB852, 5'b00001, 5'b00001);
    add_vec(0, '0, '0, 1, 0, 0, 1, 0, '0, '0, 5'b00001);
    add_vec(0, '0, '0, 0, 1, 0, 1, 0, '0, '0, '0);
    // Fill, refuse, pop two, push two, drain in order.
    add_vec(1, ent(1), '0, 0, 0, 1, 1, 1, ent(1), '0, '0);
    add_vec(1, ent(2), '0, 0, 0, 2, 1, 1, ent(1), '0, '0);
    add_vec(1, ent(3), '0, 0, 0, 3, 1, 1, ent(1), '0, '0);
    add_vec(1, ent(4), '0, 0, 0, 4, 0, 1, ent(1), '0, '0);
    add_vec(1, ent(5), '0, 0, 0, 4, 0, 1, ent(1), '0, '0);
    add_vec(0, '0, '0, 1, 0, 3, 1, 1, ent(2), '0, '0);
    add_vec(0, '0, '0, 1, 0, 2, 1, 1, ent(3), '0, '0);
    add_vec(1, ent(5), '0, 0, 0, 3, 1, 1, ent(3), '0, '0);
    add_vec(1, ent(6), '0, 0, 0, 4, 0, 1, ent(3), '0, '0);
    add_vec(0, '0, '0, 1, 0, 3, 1, 1, ent(4), '0, '0);
    add_vec(0, '0, '0, 1, 0, 2, 1, 1, ent(5), '0, '0);
    add_vec(0, '0, '0, 1, 0, 1, 1, 1, ent(6), '0, '0);
    add_vec(0, '0, '0, 1, 0, 0, 1, 0, '0, '0, '0);
    // Full with simultaneous offer and pop: offer refused, taken next cycle.
    add_vec(1, ent(7),  '0, 0, 0, 1, 1, 1, ent(7), '0, '0);
    add_vec(1, ent(8),  '0, 0, 0, 2, 1, 1, ent(7), '0, '0);
    add_vec(1, ent(9),  '0, 0, 0, 3, 1, 1, ent(7), '0, '0);
    add_vec(1, ent(10), '0, 0, 0, 4, 0, 1, ent(7), '0, '0);
    add_vec(1, ent(11), '0, 1, 0, 3, 1, 1, ent(8), '0, '0);
    add_vec(1, ent(11), '0, 0, 0, 4, 0, 1, ent(8), '0, '0);
    add_vec(0, '0, '0, 1, 0, 3, 1, 1, ent(9), '0, '0);
    add_vec(0, '0, '0, 1, 0, 2, 1, 1, ent(10), '0, '0);
    add_vec(0, '0, '0, 1, 0, 1, 1, 1, ent(11), '0, '0);
    add_vec(0, '0, '0, 1, 0, 0, 1, 0, '0, '0, '0);
    // Sticky accumulation and clear-with-push.
    add_vec(1, ent(12), 5'b00100, 1, 0, 1, 1, 1, ent(12), 5'b00100, 5'b00100);
    add_vec(1, ent(13), 5'b10000, 1, 0, 1, 1, 1, ent(13), 5'b10000, 5'b10100);
    add_vec(1, ent(14), 5'b00010, 1, 1, 1, 1, 1, ent(14), 5'b00010, 5'b00010);
    add_vec(0, '0, '0, 1, 0, 0, 1, 0, '0, '0, 5'b00010);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset");
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].in_valid, vecs[i].in_result, vecs[i].in_flags, 1'b0,
                     vecs[i].out_ready, vecs[i].clr_flags);
      name = $sformatf("vec%0d", i);
      check({name, ".t_count"},  64'(count),        64'(vecs[i].exp_count));
      check({name, ".t_ready"},  64'(in_ready),     64'(vecs[i].exp_ready));
      check({name, ".t_valid"},  64'(out_valid),    64'(vecs[i].exp_valid));
      check({name, ".t_result"}, out_result,        vecs[i].exp_result);
      check({name, ".t_flags"},  64'(out_flags),    64'(vecs[i].exp_oflags));
      check({name, ".t_sticky"}, 64'(sticky_flags), 64'(vecs[i].exp_sticky));
      check_output(name);
    end

    // Denormal counter saturation under continuous push/pop.
    for (int i = 0; i < 260; i++) begin
      apply_stimulus(1'b1, {$urandom(), $urandom()}, 5'd0, 1'b1, 1'b1, 1'b0);
      check_output($sformatf("denorm%0d", i));
    end
    check("denorm_saturated", 64'(denorm_cnt), 64'd255);
    apply_stimulus(1'b1, 64'h5, 5'd0, 1'b1, 1'b1, 1'b1);
    check("denorm_clr_push", 64'(denorm_cnt), 64'd1);
    check_output("denorm_clr_push");

    // Random traffic: fill-biased half then drain-biased half.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     (i < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0),
                     $urandom_range(0, 15) == 0);
      check_output($sformatf("rand%0d", i));
    end

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < DEPTH + 1; i++)
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b1, ent(20 + i), 5'b00011, 1'b1, 1'b0, 1'b0);
    check_output("pre_reset");
    check("pre_reset.three", 64'(count), 64'd3);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_output("async_reset");
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(1'b1, 64'h1, 5'd0, 1'b0, 1'b0, 1'b0);
    check("after_reset.head", out_result, 64'h1);
    check("after_reset.count", 64'(count), 64'd1);
    check_output("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpadd_result_queue.md
FPADD_RESULT_QUEUE -- requirements
Module: fpadd_result_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of queue entries; power of two, 2..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  adder result offered this cycle.
REQ-005 Port: in_result  input  64  adder AS_Result.
REQ-006 Port: in_flags  input  5  adder Flags: [4] invalid, [3] div-by-zero, [2] overflow, [1] underflow, [0] inexact.
REQ-007 Port: in_denorm  input  1  adder Denorm.
REQ-008 Port: in_ready  output  1  queue accepts an entry this cycle.
REQ-009 Port: out_valid  output  1  head entry present.
REQ-010 Port: out_ready  input  1  consumer takes the head entry this cycle.
REQ-011 Port: out_result  output  64  head result.
REQ-012 Port: out_flags  output  5  head flags.
REQ-013 Port: out_denorm  output  1  head denorm bit.
REQ-014 Port: clr_flags  input  1  synchronous clear of the sticky flags.
REQ-015 Port: sticky_flags  output  5  OR-accumulated flags of all accepted results since the last clear.
REQ-016 Port: denorm_cnt  output  8  saturating count of accepted results with in_denorm=1.
REQ-017 Port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-018 The block SHALL be a circular FIFO of DEPTH entries, each holding {result, flags, denorm}, with read and write pointers that wrap from DEPTH-1 to 0.
REQ-019 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-020 in_ready SHALL be 1 exactly when count < DEPTH; it SHALL NOT depend combinationally on out_ready (full plus simultaneous pop still refuses the push).
REQ-021 out_valid SHALL be 1 exactly when count != 0; out_result, out_flags and out_denorm SHALL show the head entry combinationally from storage, and SHALL be 0 when count = 0.
REQ-022 Latency: an entry pushed in cycle N SHALL be visible at the outputs from cycle N+1 if the queue was empty; there is no fall-through in the same cycle.
REQ-023 A simultaneous push and pop when 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-024 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 A push when full or a pop when empty SHALL NOT occur; in_valid and out_ready are then ignored and no state changes.
REQ-026 On each push, sticky_flags SHALL become sticky_flags | in_flags at the next edge.
REQ-027 clr_flags=1 without a push SHALL set sticky_flags to 0; clr_flags=1 with a push SHALL set sticky_flags to in_flags (clear first, then accumulate).
REQ-028 On each push with in_denorm=1, denorm_cnt SHALL increment by 1 and saturate at 255; clr_flags SHALL also clear denorm_cnt, with the same push-wins rule as REQ-027.
REQ-029 Entry storage SHALL need no reset; a stale entry SHALL never reach the outputs.

Reset
REQ-030 While reset=1, pointers, count, sticky_flags and denorm_cnt SHALL be 0, in_ready SHALL be 1, and out_valid, out_result, out_flags and out_denorm SHALL be 0, independent of clk.
REQ-031 A reset asserted mid-operation SHALL discard all queued entries; the first push after deassertion SHALL appear as the head.

Verification
REQ-032 Single entry: push in_result=64'h404FD1EB851EB852, in_flags=5'b00001 with out_ready=0. Next cycle out_valid=1, out_result=64'h404FD1EB851EB852, out_flags=5'b00001, count=1, sticky_flags=5'b00001.
REQ-033 Fill and wrap: push 4 entries with out_ready=0, giving in_ready=0 and count=4. A 5th push is refused. Pop 2 and push 2 more (A..F). Draining returns C, D, E, F in order, and count ends at 0.
REQ-034 Full with simultaneous in_valid and out_ready: count goes 4 to 3, the offered entry is not stored, and it is accepted the following cycle.
REQ-035 Sticky flags: push flags 5'b00100 then 5'b10000, giving sticky_flags=5'b10100. Then clr_flags=1 together with a push of flags 5'b00010 gives sticky_flags=5'b00010.
REQ-036 Denorm saturation: 260 pushes with in_denorm=1 (continuous pop) give denorm_cnt=255.
REQ-037 Reset mid-operation: with 3 entries queued, assert reset asynchronously between edges. Outputs go 0 and in_ready goes 1 immediately. After deassertion, pushing 64'h1 gives head 64'h1 with count=1.
